// File: rtl/byte_lane_ram.sv
// Single-port 16-bit word RAM with a little-endian byte-addressed interface.
// Storage is kept as two 8-bit lane arrays so program images can be preloaded per lane.
module byte_lane_ram #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 2 ** (ADDR_WIDTH - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr,
  input  logic                  byt,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data
);

  logic [7:0] mem_hi [0:DEPTH_WORDS-1];
  logic [7:0] mem_lo [0:DEPTH_WORDS-1];

  logic [ADDR_WIDTH-2:0] word_idx_s;
  logic                  odd_s;
  logic                  wr_hi_s;
  logic                  wr_lo_s;
  logic [7:0]            wr_hi_data_s;

  logic [15:0] word_q;
  logic [15:0] word_d;
  logic        sel_q;
  logic        sel_d;
  logic        byt_q;
  logic        byt_d;
  logic [15:0] rd_data_s;

  assign word_idx_s = addr[ADDR_WIDTH-1:1];
  assign odd_s      = addr[0];

  // Lane write enables; a byte write always carries its data in wr_data[7:0].
  always_comb begin
    wr_hi_s      = 1'b0;
    wr_lo_s      = 1'b0;
    wr_hi_data_s = wr_data[15:8];
    if (wr && rst) begin
      if (byt) begin
        wr_hi_s      = odd_s;
        wr_lo_s      = ~odd_s;
        wr_hi_data_s = wr_data[7:0];
      end else begin
        wr_hi_s = 1'b1;
        wr_lo_s = 1'b1;
      end
    end else begin
      wr_hi_s = 1'b0;
      wr_lo_s = 1'b0;
    end
  end

  // Storage lanes: never reset, so preloaded images survive reset pulses.
  always_ff @(posedge clk) begin
    if (wr_hi_s) begin
      mem_hi[word_idx_s] <= wr_hi_data_s;
    end
    if (wr_lo_s) begin
      mem_lo[word_idx_s] <= wr_data[7:0];
    end
  end

  // Read capture is unconditional, giving read-first behaviour on a collision.
  always_comb begin
    word_d = {mem_hi[word_idx_s], mem_lo[word_idx_s]};
    sel_d  = odd_s;
    byt_d  = byt;
  end

  // Read-data register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= 16'h0000;
      sel_q  <= 1'b0;
      byt_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      sel_q  <= sel_d;
      byt_q  <= byt_d;
    end
  end

  // Output formatting: byte reads are zero-extended from the selected lane.
  always_comb begin
    rd_data_s = word_q;
    if (byt_q) begin
      if (sel_q) begin
        rd_data_s = {8'h00, word_q[15:8]};
      end else begin
        rd_data_s = {8'h00, word_q[7:0]};
      end
    end else begin
      rd_data_s = word_q;
    end
  end

  assign rd_data = rd_data_s;

endmodule

// File: tb/tb_byte_lane_ram.sv
// Directed self-checking bench for byte_lane_ram.
module tb_byte_lane_ram;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        wr;
  logic        byt;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  byte_lane_ram #(.ADDR_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (wr),
    .byt     (byt),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] lat_data [0:3];

  initial begin
    rst = 1'b0; wr = 1'b0; byt = 1'b0; addr = 16'h0000; wr_data = 16'h0000;
    dut.mem_hi[15'h2000] = 8'h12;
    dut.mem_lo[15'h2000] = 8'h34;
    lat_data[0] = 16'h1001; lat_data[1] = 16'h2302;
    lat_data[2] = 16'h4503; lat_data[3] = 16'h6704;
    for (int i = 0; i < 4; i++) begin
      dut.mem_hi[15'h0010 + 15'(i)] = lat_data[i][15:8];
      dut.mem_lo[15'h0010 + 15'(i)] = lat_data[i][7:0];
    end
    addr = 16'h4000;
    step();
    step();
    check("reset_state", rd_data, 16'h0000);
    rst = 1'b1;

    // Preload and read
    addr = 16'h4000; byt = 1'b0;
    step();
    check("preload_word", rd_data, 16'h1234);

    // Word write / read, then misaligned address hits the same word
    wr = 1'b1; addr = 16'h0100; wr_data = 16'hBEEF;
    step();
    wr = 1'b0;
    step();
    check("word_wr_rd", rd_data, 16'hBEEF);
    wr = 1'b1; addr = 16'h0101; wr_data = 16'hCAFE;
    step();
    wr = 1'b0; addr = 16'h0100;
    step();
    check("misaligned_wr", rd_data, 16'hCAFE);
    addr = 16'h0101;
    step();
    check("misaligned_rd", rd_data, 16'hCAFE);

    // Byte lanes
    wr = 1'b1; byt = 1'b0; addr = 16'h0200; wr_data = 16'hAABB;
    step();
    byt = 1'b1; wr_data = 16'hFF11;
    step();
    wr = 1'b0; byt = 1'b0;
    step();
    check("byte_lo_wr", rd_data, 16'hAA11);
    wr = 1'b1; byt = 1'b1; addr = 16'h0201; wr_data = 16'hEE22;
    step();
    wr = 1'b0; byt = 1'b0; addr = 16'h0200;
    step();
    check("byte_hi_wr", rd_data, 16'h2211);
    byt = 1'b1; addr = 16'h0200;
    step();
    check("byte_rd_even", rd_data, 16'h0011);
    addr = 16'h0201;
    step();
    check("byte_rd_odd", rd_data, 16'h0022);

    // Read-first collision
    wr = 1'b1; byt = 1'b0; addr = 16'h0300; wr_data = 16'h5555;
    step();
    wr_data = 16'h6666;
    step();
    check("collision_old", rd_data, 16'h5555);
    wr = 1'b0;
    step();
    check("collision_new", rd_data, 16'h6666);

    // Asynchronous reset mid-cycle, writes blocked, contents retained
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", rd_data, 16'h0000);
    wr = 1'b1; addr = 16'h0100; wr_data = 16'hDEAD;
    step();
    check("reset_hold", rd_data, 16'h0000);
    wr = 1'b0;
    rst = 1'b1;
    step();
    check("retained", rd_data, 16'hCAFE);

    // Back-to-back reads: one-cycle latency, no bubbles
    for (int i = 0; i < 4; i++) begin
      addr = 16'h0020 + 16'(2 * i);
      #4;
      if (i == 0) check("hold_prev", rd_data, 16'hCAFE);
      else        check("hold_prev", rd_data, lat_data[i-1]);
      @(posedge clk);
      #1;
      check("latency", rd_data, lat_data[i]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
